program_loader: RTL
===================

Name: program_loader

Overview:
Write-side companion of the instruction ROM. It receives the program image as a byte stream from the UART receiver and assembles 16-bit instruction words, high byte first. It then drives the memory write port sequentially from address 0 until a HALT word is written or the memory fills. It sits between uart_rx and program_memory and is armed by the debug unit before the CPU is released from stall.

Parameters:
RAM_WIDTH, 16, instruction word width; fixed at 2 bytes; any other value is a synthesis error.
RAM_ADDR_BITS, 11, width of the write address.
MEM_DEPTH, 30, number of words the program memory holds; last valid address is MEM_DEPTH-1.
HALT_WORD, 16'h0000, word that terminates the load.
TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between high byte and low byte.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse that arms a new load.
rx_data  input  8  received byte; valid only while rx_done=1.
rx_done  input  1  one-cycle strobe from uart_rx.
wr_en  output  1  memory write strobe, one cycle per word.
wr_addr  output  RAM_ADDR_BITS  write address.
wr_data  output  RAM_WIDTH  assembled word.
loading  output  1  high from the accepted start until DONE or ERROR.
load_done  output  1  level; high after a successful load until the next start.
load_error  output  1  level; high after timeout or overflow until the next start.
word_count  output  RAM_ADDR_BITS  words written in the current or last load.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; wr_en=0, wr_addr=0, wr_data=0, loading=0, load_done=0, load_error=0, word_count=0, timeout counter=0.
- All outputs are registered on posedge clk. They are therefore stable at the negedge where program_memory samples.
- States: IDLE, WAIT_HI, WAIT_LO, WRITE, DONE, ERROR.
- IDLE / DONE / ERROR + start:
  - go to WAIT_HI.
  - clear wr_addr, word_count, load_done and load_error.
  - set loading=1.
  - rx_done is ignored in these states.
- WAIT_HI + rx_done: latch rx_data into wr_data[15:8], clear the timeout counter, go to WAIT_LO.
- WAIT_LO:
  - Each cycle without rx_done increments the timeout counter.
  - When the counter reaches TIMEOUT_CYCLES-1, go to ERROR with load_error=1.
  - rx_done latches rx_data into wr_data[7:0] and goes to WRITE.
- WRITE (exactly one cycle): wr_en=1 with current wr_addr/wr_data. Latency: wr_en is high in the cycle after the rx_done that carried the low byte.
- Next state after WRITE:
  - If wr_data==HALT_WORD: go to DONE, load_done=1. The HALT word is written and counted.
  - Else if wr_addr==MEM_DEPTH-1: go to ERROR, load_error=1 (overflow; the last word is written).
  - Else: wr_addr+1, go to WAIT_HI.
- word_count increments in the WRITE cycle.
- loading drops on entry to DONE or ERROR.
- start while loading=1 is ignored; it does not restart the load.
- rx_done coinciding with start in IDLE: start wins and the byte is discarded.
- No timeout in WAIT_HI; the loader waits indefinitely for the first byte of a word.
- Reset mid-load aborts immediately. Words already written stay in memory, and wr_en is never left high.
- wr_en is never asserted outside WRITE. wr_addr never exceeds MEM_DEPTH-1.

Decomposition:
- A shared package or include holds the state encoding localparams (3 bits), HALT_WORD and the byte order constant (HI_FIRST=1).
- One sub-module, loader_timeout_counter: clear, enable, terminal-count pulse, width $clog2(TIMEOUT_CYCLES).
- The FSM and datapath stay in program_loader.

Test Plan:
1. Reset, start, bytes 8'h12,8'h34,8'h00,8'h00 -> writes 16'h1234@0 and 16'h0000@1, each with exactly one wr_en cycle; load_done=1, word_count=2, loading=0.
2. Low byte delivered in cycle N -> wr_en=1 in cycle N+1 only, with wr_data stable across the following negedge.
3. start, byte 8'hAB, then no rx_done for TIMEOUT_CYCLES (set to 16 in the bench) -> load_error=1, no wr_en, wr_addr=0.
4. MEM_DEPTH=4; start and 4 non-halt words -> writes at addresses 0..3, then load_error=1, word_count=4, no address 4.
5. Second start pulse mid-load, and rx_done bytes before any start -> neither changes state, address or writes.
6. rst_n low between the high and low byte of word 3 -> all outputs clear asynchronously; after release, start reloads from address 0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, halt word and
// the byte order used when assembling instruction words.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_HI = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  localparam logic [15:0] HALT_WORD_DEFAULT = 16'h0000;
  localparam bit          HI_FIRST          = 1'b1;

  // Drops a received byte into the upper or lower half of a 16-bit word.
  function automatic logic [15:0] place_byte(input logic [15:0] word,
                                             input logic [7:0]  b,
                                             input logic        upper);
    place_byte = upper ? {b, word[7:0]} : {word[15:8], b};
  endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles and flags the terminal count
// so the loader can abandon a word whose low byte never arrives.
module loader_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last  = (count == LAST);
  assign terminal = enable && at_last;

  // Saturates at LAST so a stalled ERROR state never wraps the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Assembles UART bytes into instruction words and writes them sequentially
// into program memory until a HALT word lands or the memory is full.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          RAM_WIDTH      = 16,
  parameter int          RAM_ADDR_BITS  = 11,
  parameter int          MEM_DEPTH      = 30,
  parameter logic [15:0] HALT_WORD      = HALT_WORD_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  output logic                     wr_en,
  output logic [RAM_ADDR_BITS-1:0] wr_addr,
  output logic [RAM_WIDTH-1:0]     wr_data,
  output logic                     loading,
  output logic                     load_done,
  output logic                     load_error,
  output logic [RAM_ADDR_BITS-1:0] word_count
);

  if (RAM_WIDTH != 16) begin : g_bad_width
    $error("program_loader: RAM_WIDTH must be 16 (two bytes per word)");
  end

  if (MEM_DEPTH < 1 || MEM_DEPTH > (1 << RAM_ADDR_BITS)) begin : g_bad_depth
    $error("program_loader: MEM_DEPTH does not fit in RAM_ADDR_BITS");
  end

  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(MEM_DEPTH - 1);

  state_t state;
  logic   idle_like;
  logic   accept_start;
  logic   to_clear;
  logic   to_enable;
  logic   timeout_hit;

  assign idle_like    = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
  assign accept_start = idle_like && start;
  assign to_clear     = accept_start || ((state == ST_WAIT_HI) && rx_done);
  assign to_enable    = (state == ST_WAIT_LO) && !rx_done;

  loader_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (to_clear),
    .enable  (to_enable),
    .terminal(timeout_hit)
  );

  // wr_en is raised on the transition into WRITE so it is high for exactly
  // the one cycle the FSM spends there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      loading    <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      word_count <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state      <= ST_WAIT_HI;
            wr_addr    <= '0;
            word_count <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            loading    <= 1'b1;
          end
        end
        ST_WAIT_HI: begin
          if (rx_done) begin
            wr_data <= place_byte(wr_data, rx_data, HI_FIRST);
            state   <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (rx_done) begin
            wr_data <= place_byte(wr_data, rx_data, !HI_FIRST);
            wr_en   <= 1'b1;
            state   <= ST_WRITE;
          end else if (timeout_hit) begin
            state      <= ST_ERROR;
            load_error <= 1'b1;
            loading    <= 1'b0;
          end
        end
        ST_WRITE: begin
          word_count <= word_count + 1'b1;
          if (wr_data == HALT_WORD) begin
            state     <= ST_DONE;
            load_done <= 1'b1;
            loading   <= 1'b0;
          end else if (wr_addr == LAST_ADDR) begin
            state      <= ST_ERROR;
            load_error <= 1'b1;
            loading    <= 1'b0;
          end else begin
            wr_addr <= wr_addr + 1'b1;
            state   <= ST_WAIT_HI;
          end
        end
        default: begin
          state   <= ST_IDLE;
          loading <= 1'b0;
        end
      endcase
    end
  end

endmodule
